// File: rtl/ppl_execute_md_if.sv
// EX-stage bundle between the ID/EX register, the execute stage and the EX/MEM boundary.
// Optional PPL_EXECUTE_DIV0_FLAG_EN adds the mDivZero retirement flag.
interface ppl_execute_md_if #(parameter int W = 32);
    logic         exValid;
    logic         exWreg;
    logic         exJal;
    logic         exAluImm;
    logic         exShift;
    logic [3:0]   exAluC;
    logic [2:0]   exMdOp;
    logic [W-1:0] expc4;
    logic [W-1:0] exDataA;
    logic [W-1:0] exDataB;
    logic [W-1:0] exDataImm;
    logic [4:0]   exReg0;
    logic         exStall;
    logic         mValid;
    logic         mWreg;
    logic [4:0]   mReg;
    logic [W-1:0] mAlu;
`ifdef PPL_EXECUTE_DIV0_FLAG_EN
    logic         mDivZero;
`endif

    modport master (
        output exValid, exWreg, exJal, exAluImm, exShift, exAluC, exMdOp,
               expc4, exDataA, exDataB, exDataImm, exReg0,
        input  exStall, mValid, mWreg, mReg, mAlu
`ifdef PPL_EXECUTE_DIV0_FLAG_EN
        , input mDivZero
`endif
    );

    modport slave (
        input  exValid, exWreg, exJal, exAluImm, exShift, exAluC, exMdOp,
               expc4, exDataA, exDataB, exDataImm, exReg0,
        output exStall, mValid, mWreg, mReg, mAlu
`ifdef PPL_EXECUTE_DIV0_FLAG_EN
        , output mDivZero
`endif
    );
endinterface

// File: rtl/ppl_execute_md.sv
// Registered MIPS execute stage with iterative multiply/divide and HI/LO.
// Optional PPL_EXECUTE_DIV0_FLAG_EN registers a divide-by-zero flag at retirement.
//
// state | meaning
// IDLE  | single-cycle ops retire each edge; an MD op latches operands and stalls
// RUN   | one shift-add / shift-subtract step per edge, W steps, stall held
// DONE  | sign fix-up, HI/LO written, MD op retires, stall released
module ppl_execute_md #(
    parameter int W        = 32,
    parameter int LINK_REG = 31
) (
    input  logic              clock,
    input  logic              resetn,
    ppl_execute_md_if.slave   bus
);
    localparam int SW = $clog2(W);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, stateNext;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opB;
    logic [W-1:0]   hi, lo;
    logic           isDiv, negA, negB;

    logic           isMd, isSignedOp, isDivOp, issue;
    logic [W-1:0]   aluA, aluB, aluRes, magA, magB;
    logic [W-1:0]   result;
    logic [4:0]     dest;
    logic [W:0]     mulHi, divTrial;
    logic [2*W-1:0] stepNext, mulRes;
    logic [W-1:0]   divQ, divR;

    assign isMd       = (bus.exMdOp >= 3'd1) && (bus.exMdOp <= 3'd4);
    assign isSignedOp = (bus.exMdOp == 3'd1) || (bus.exMdOp == 3'd3);
    assign isDivOp    = (bus.exMdOp == 3'd3) || (bus.exMdOp == 3'd4);
    assign issue      = (state == IDLE) && bus.exValid && isMd;

    assign aluA = bus.exShift  ? bus.exDataImm : bus.exDataA;
    assign aluB = bus.exAluImm ? bus.exDataImm : bus.exDataB;
    assign magA = (isSignedOp && bus.exDataA[W-1]) ? -bus.exDataA : bus.exDataA;
    assign magB = (isSignedOp && bus.exDataB[W-1]) ? -bus.exDataB : bus.exDataB;

    always_comb begin
        aluRes = '0;
        casez (bus.exAluC)
            4'b?000: aluRes = aluA + aluB;
            4'b?100: aluRes = aluA - aluB;
            4'b?001: aluRes = aluA & aluB;
            4'b?101: aluRes = aluA | aluB;
            4'b?010: aluRes = aluA ^ aluB;
            4'b?110: aluRes = aluB << 16;
            4'b0011: aluRes = aluB << aluA[SW-1:0];
            4'b0111: aluRes = aluB >> aluA[SW-1:0];
            4'b1111: aluRes = W'($signed(aluB) >>> aluA[SW-1:0]);
            default: aluRes = '0;
        endcase
    end

    always_comb begin
        result = aluRes;
        dest   = bus.exReg0;
        if (bus.exJal) begin
            result = bus.expc4 + W'(4);
            dest   = 5'(LINK_REG);
        end else if (bus.exMdOp == 3'd5) begin
            result = hi;
        end else if (bus.exMdOp == 3'd6) begin
            result = lo;
        end
    end

    // acc holds {partial product | remainder, multiplier | quotient}
    assign mulHi    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opB} : '0);
    assign divTrial = acc[2*W-1:W-1] - {1'b0, opB};
    always_comb begin
        if (isDiv)
            stepNext = divTrial[W] ? {acc[2*W-2:0], 1'b0}
                                   : {divTrial[W-1:0], acc[W-2:0], 1'b1};
        else
            stepNext = {mulHi, acc[W-1:1]};
    end

    assign mulRes = (negA ^ negB) ? -acc : acc;
    assign divQ   = (negA ^ negB) ? -acc[W-1:0] : acc[W-1:0];
    // with a zero divisor the remainder ends up as |A|, so this also restores A
    assign divR   = negA ? -acc[2*W-1:W] : acc[2*W-1:W];

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (issue) stateNext = RUN;
            RUN:     if (cnt == CW'(W - 1)) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.exStall = issue || (state == RUN);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= stateNext;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            acc        <= '0;
            opB        <= '0;
            hi         <= '0;
            lo         <= '0;
            isDiv      <= 1'b0;
            negA       <= 1'b0;
            negB       <= 1'b0;
            bus.mValid <= 1'b0;
            bus.mWreg  <= 1'b0;
            bus.mReg   <= '0;
            bus.mAlu   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        acc        <= {{W{1'b0}}, magA};
                        opB        <= magB;
                        isDiv      <= isDivOp;
                        negA       <= isSignedOp && bus.exDataA[W-1];
                        negB       <= isSignedOp && bus.exDataB[W-1];
                        cnt        <= '0;
                        bus.mValid <= 1'b0;
                        bus.mWreg  <= 1'b0;
                    end else begin
                        bus.mValid <= bus.exValid;
                        bus.mWreg  <= bus.exValid && bus.exWreg;
                        bus.mReg   <= dest;
                        bus.mAlu   <= result;
                    end
                end
                RUN: begin
                    acc        <= stepNext;
                    cnt        <= cnt + 1'b1;
                    bus.mValid <= 1'b0;
                    bus.mWreg  <= 1'b0;
                end
                DONE: begin
                    if (isDiv) begin
                        hi <= divR;
                        lo <= (opB == '0) ? '1 : divQ;
                    end else begin
                        hi <= mulRes[2*W-1:W];
                        lo <= mulRes[W-1:0];
                    end
                    bus.mValid <= 1'b1;
                    bus.mWreg  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef PPL_EXECUTE_DIV0_FLAG_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) bus.mDivZero <= 1'b0;
        else         bus.mDivZero <= (state == DONE) && isDiv && (opB == '0);
    end
`endif
endmodule

// File: tb/tb_ppl_execute_md.sv
// Directed bench for ppl_execute_md (W=32): single-cycle ops, MD ops, div-by-zero, reset abort.
module tb_ppl_execute_md;
    logic clock = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    ppl_execute_md_if #(.W(32)) bus ();
    ppl_execute_md #(.W(32), .LINK_REG(31)) dut (.clock(clock), .resetn(resetn), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setIn(input logic v, input logic wr, input logic jal, input logic aImm,
                         input logic sh, input logic [3:0] c, input logic [2:0] md,
                         input logic [31:0] pc4, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] r);
        bus.exValid = v;   bus.exWreg = wr;  bus.exJal = jal; bus.exAluImm = aImm;
        bus.exShift = sh;  bus.exAluC = c;   bus.exMdOp = md; bus.expc4 = pc4;
        bus.exDataA = a;   bus.exDataB = b;  bus.exDataImm = imm; bus.exReg0 = r;
    endtask

    task automatic aluOp(input string tag, input logic [3:0] c, input logic aImm, input logic sh,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] exp);
        setIn(1, 1, 0, aImm, sh, c, 3'd0, 32'h0, a, b, imm, 5'd4);
        tick();
        chk(tag, bus.mAlu, exp);
    endtask

    task automatic runMd(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int n = 0;
        setIn(1, 0, 0, 0, 0, 4'd0, op, 32'h0, a, b, 32'h0, 5'd0);
        #1;
        while (bus.exStall && n < 100) begin
            n++;
            tick();
        end
        chk({tag, "_stall"}, 32'(n), 32'd33);
        bus.exValid = 1'b0;
        bus.exMdOp  = 3'd0;
        tick();
        chk({tag, "_retire"}, {30'b0, bus.mValid, bus.mWreg}, 32'h2);
    endtask

    task automatic readHiLo(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
        setIn(1, 1, 0, 0, 0, 4'd0, 3'd5, 32'h0, 32'h0, 32'h0, 32'h0, 5'd8);
        tick();
        chk({tag, "_hi"}, bus.mAlu, expHi);
        bus.exMdOp = 3'd6;
        tick();
        chk({tag, "_lo"}, bus.mAlu, expLo);
        bus.exValid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        setIn(0, 0, 0, 0, 0, 4'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out", {bus.mValid, bus.mWreg, bus.mReg, bus.exStall}, 32'h0);
        chk("rst_alu", bus.mAlu, 32'h0);
        resetn = 1'b1;

        setIn(1, 1, 1, 0, 0, 4'd0, 3'd0, 32'h400, 32'h0, 32'h0, 32'h0, 5'd5);
        tick();
        chk("jal_alu", bus.mAlu, 32'h404);
        chk("jal_reg", {27'b0, bus.mReg}, 32'd31);
        chk("jal_valid", {31'b0, bus.mValid}, 32'd1);

        setIn(1, 1, 0, 0, 0, 4'd0, 3'd0, 32'h0, 32'd7, 32'd9, 32'h0, 5'd3);
        #1;
        chk("add_stall", {31'b0, bus.exStall}, 32'd0);
        tick();
        chk("add_alu", bus.mAlu, 32'd16);
        chk("add_regwr", {26'b0, bus.mReg, bus.mWreg}, {26'b0, 5'd3, 1'b1});

        aluOp("sub", 4'b0100, 0, 0, 32'd5, 32'd9, 32'h0, 32'hFFFF_FFFC);
        aluOp("andi", 4'b0001, 1, 0, 32'hF0F0_1234, 32'h0, 32'h0000_FF00, 32'h0000_1200);
        aluOp("sra", 4'b1111, 0, 1, 32'h0, 32'h8000_0000, 32'd4, 32'hF800_0000);
        aluOp("srl", 4'b0111, 0, 1, 32'h0, 32'h8000_0000, 32'd4, 32'h0800_0000);
        aluOp("lui", 4'b0110, 1, 0, 32'h0, 32'h0, 32'h0000_ABCD, 32'hABCD_0000);

        runMd("mult", 3'd1, 32'hFFFF_FFFD, 32'd5);
        readHiLo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        runMd("multu", 3'd2, 32'hFFFF_FFFF, 32'd2);
        readHiLo("multu", 32'h1, 32'hFFFF_FFFE);
        runMd("divu", 3'd4, 32'd100, 32'd7);
        readHiLo("divu", 32'd2, 32'd14);
        runMd("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
        readHiLo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runMd("divmin", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        readHiLo("divmin", 32'h0, 32'h8000_0000);

        runMd("div0", 3'd3, 32'h1234_5678, 32'h0);
`ifdef PPL_EXECUTE_DIV0_FLAG_EN
        chk("div0_flag", {31'b0, bus.mDivZero}, 32'd1);
`endif
        readHiLo("div0", 32'h1234_5678, 32'hFFFF_FFFF);
`ifdef PPL_EXECUTE_DIV0_FLAG_EN
        chk("div0_flag_clr", {31'b0, bus.mDivZero}, 32'd0);
`endif

        setIn(0, 0, 0, 0, 0, 4'd0, 3'd3, 32'h0, 32'd9, 32'd3, 32'h0, 5'd0);
        #1;
        chk("nv_md_stall", {31'b0, bus.exStall}, 32'd0);
        tick();
        chk("nv_md_valid", {31'b0, bus.mValid}, 32'd0);
        readHiLo("nv_md", 32'h1234_5678, 32'hFFFF_FFFF);

        setIn(1, 0, 0, 0, 0, 4'd0, 3'd2, 32'h0, 32'h1234, 32'h10, 32'h0, 5'd0);
        tick();
        repeat (10) tick();
        chk("run_stall", {31'b0, bus.exStall}, 32'd1);
        bus.exValid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("abort_stall", {31'b0, bus.exStall}, 32'd0);
        chk("abort_valid", {31'b0, bus.mValid}, 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        readHiLo("abort", 32'h0, 32'h0);
        chk("abort_idle_valid", {31'b0, bus.mValid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
